// File: rtl/id_ex_issue_if.sv
// Decode-to-issue bundle: id_* fields flow in from decode,
// ex_* fields are the registered ID/EX outputs feeding the ALU.
interface id_ex_issue_if #(
    parameter int CTRL_W = 16
);
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [31:0]       id_imm;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_mem_read;
    logic              id_reg_write;

    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_op1;
    logic [31:0]       ex_op2;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_mem_read;
    logic              ex_reg_write;

    modport master (
        output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd,
        output id_ctrl, id_mem_read, id_reg_write,
        input  ex_valid, ex_pc, ex_imm, ex_op1, ex_op2,
        input  ex_rs1, ex_rs2, ex_rd, ex_ctrl,
        input  ex_mem_read, ex_reg_write
    );

    modport slave (
        input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd,
        input  id_ctrl, id_mem_read, id_reg_write,
        output ex_valid, ex_pc, ex_imm, ex_op1, ex_op2,
        output ex_rs1, ex_rs2, ex_rd, ex_ctrl,
        output ex_mem_read, ex_reg_write
    );
endinterface

// File: rtl/id_ex_issue.sv
// ID/EX issue stage: operand bypass from EX/MEM/WB, one-bubble
// load-use interlock, branch flush and downstream freeze.
module id_ex_issue #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_issue_if.slave     bus,
    input  logic [31:0]      rf_rd0,
    input  logic [31:0]      rf_rd1,
    input  logic [31:0]      ex_alu_result,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      mem_data,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    input  logic             flush,
    input  logic             ex_stall,
    output logic             id_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    logic        ex_fwd;
    logic        hz;
    logic [31:0] op1;
    logic [31:0] op2;

    function automatic logic [31:0] pick(
        input logic [4:0]  s,
        input logic [31:0] rf,
        input logic        e_en,
        input logic [4:0]  e_rd,
        input logic [31:0] e_val,
        input logic        m_en,
        input logic [4:0]  m_rd,
        input logic [31:0] m_val,
        input logic        w_en,
        input logic [4:0]  w_rd,
        input logic [31:0] w_val
    );
        logic [31:0] r;
        if (s == 5'd0)
            r = 32'd0;
        else if (e_en && e_rd == s)
            r = e_val;
        else if (m_en && m_rd == s)
            r = m_val;
        else if (w_en && w_rd == s)
            r = w_val;
        else
            r = rf;
        return r;
    endfunction

    // hazard detection, stall request and bypassed operands
    always_comb begin
        ex_fwd = bus.ex_valid & bus.ex_reg_write & ~bus.ex_mem_read;
        hz = bus.id_valid & bus.ex_valid & bus.ex_mem_read
           & (bus.ex_rd != 5'd0)
           & ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));
        id_stall = (hz & ~flush) | ex_stall;
        op1 = pick(bus.id_rs1, rf_rd0,
                   ex_fwd, bus.ex_rd, ex_alu_result,
                   mem_reg_write, mem_rd, mem_data,
                   wb_reg_write, wb_rd, wb_data);
        op2 = pick(bus.id_rs2, rf_rd1,
                   ex_fwd, bus.ex_rd, ex_alu_result,
                   mem_reg_write, mem_rd, mem_data,
                   wb_reg_write, wb_rd, wb_data);
    end

    // ID/EX register: freeze > flush > load-use bubble > issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_imm       <= '0;
            bus.ex_op1       <= '0;
            bus.ex_op2       <= '0;
            bus.ex_rs1       <= '0;
            bus.ex_rs2       <= '0;
            bus.ex_rd        <= '0;
            bus.ex_ctrl      <= '0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            stall_cnt        <= '0;
        end else if (!ex_stall) begin
            if (flush || hz) begin
                bus.ex_valid     <= 1'b0;
                bus.ex_pc        <= '0;
                bus.ex_imm       <= '0;
                bus.ex_op1       <= '0;
                bus.ex_op2       <= '0;
                bus.ex_rs1       <= '0;
                bus.ex_rs2       <= '0;
                bus.ex_rd        <= '0;
                bus.ex_ctrl      <= '0;
                bus.ex_mem_read  <= 1'b0;
                bus.ex_reg_write <= 1'b0;
                if (!flush && stall_cnt != {CNT_W{1'b1}})
                    stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                bus.ex_valid     <= bus.id_valid;
                bus.ex_pc        <= bus.id_pc;
                bus.ex_imm       <= bus.id_imm;
                bus.ex_op1       <= op1;
                bus.ex_op2       <= op2;
                bus.ex_rs1       <= bus.id_rs1;
                bus.ex_rs2       <= bus.id_rs2;
                bus.ex_rd        <= bus.id_rd;
                bus.ex_ctrl      <= bus.id_ctrl;
                bus.ex_mem_read  <= bus.id_valid & bus.id_mem_read;
                bus.ex_reg_write <= bus.id_valid & bus.id_reg_write;
            end
        end
    end

endmodule
